// File: rtl/shape_scan_sched.sv
// Per-frame shape-table scheduler: fetches one record at a time and hands it to the drawer.
// Optional build macro SHAPE_SCAN_SKIP_EMPTY_EN drops records whose ty field is zero.
module shape_scan_sched #(
  parameter int CORDW = 9,
  parameter int DATAW = 12,
  parameter int NUMW  = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [NUMW-1:0]  shape_count,
  output logic [NUMW-1:0]  rd_id,
  output logic             rd_trigger,
  input  logic             rd_busy,
  input  logic [DATAW-1:0] rd_ty,
  input  logic [CORDW-1:0] rd_x,
  input  logic [CORDW-1:0] rd_y,
  input  logic [DATAW-1:0] rd_size,
  input  logic [DATAW-1:0] rd_rotate,
  output logic             shp_valid,
  input  logic             shp_ready,
  output logic [NUMW-1:0]  shp_id,
  output logic [DATAW-1:0] shp_ty,
  output logic [CORDW-1:0] shp_x,
  output logic [CORDW-1:0] shp_y,
  output logic [DATAW-1:0] shp_size,
  output logic [DATAW-1:0] shp_rotate,
  output logic             scan_busy,
  output logic             scan_done,
  output logic             overrun
);

  // state   | meaning
  // IDLE    | waiting for frame_start
  // TRIG    | one-cycle fetch request for the current id
  // WAIT    | reader busy; capture record when it drops
  // PRESENT | record offered to the drawer until accepted
  // DONE    | one-cycle scan_done pulse
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_TRIG    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [NUMW-1:0] ONE = {{(NUMW-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [NUMW-1:0]  count_q, count_d;
  logic [NUMW-1:0]  id_q, id_d;
  logic             shp_valid_q, shp_valid_d;
  logic [NUMW-1:0]  shp_id_q, shp_id_d;
  logic [DATAW-1:0] shp_ty_q, shp_ty_d;
  logic [CORDW-1:0] shp_x_q, shp_x_d;
  logic [CORDW-1:0] shp_y_q, shp_y_d;
  logic [DATAW-1:0] shp_size_q, shp_size_d;
  logic [DATAW-1:0] shp_rotate_q, shp_rotate_d;
  logic             overrun_q, overrun_d;
  logic             last_id;
  logic             capture;

  // count is never 0 outside IDLE/DONE, so count-1 cannot underflow where it is used
  assign last_id = (id_q == (count_q - ONE));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    id_d         = id_q;
    shp_valid_d  = shp_valid_q;
    shp_id_d     = shp_id_q;
    shp_ty_d     = shp_ty_q;
    shp_x_d      = shp_x_q;
    shp_y_d      = shp_y_q;
    shp_size_d   = shp_size_q;
    shp_rotate_d = shp_rotate_q;
    overrun_d    = overrun_q | (frame_start && (state_q != S_IDLE));
    capture      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          count_d = shape_count;
          id_d    = '0;
          state_d = (shape_count == '0) ? S_DONE : S_TRIG;
        end
      end
      S_TRIG: state_d = S_WAIT;
      S_WAIT: begin
        if (!rd_busy) begin
`ifdef SHAPE_SCAN_SKIP_EMPTY_EN
          if (rd_ty == '0) begin
            if (last_id) begin
              state_d = S_DONE;
            end else begin
              id_d    = id_q + ONE;
              state_d = S_TRIG;
            end
          end else begin
            capture = 1'b1;
          end
`else
          capture = 1'b1;
`endif
        end
      end
      S_PRESENT: begin
        if (shp_ready) begin
          shp_valid_d = 1'b0;
          if (last_id) begin
            state_d = S_DONE;
          end else begin
            id_d    = id_q + ONE;
            state_d = S_TRIG;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      shp_valid_d  = 1'b1;
      shp_id_d     = id_q;
      shp_ty_d     = rd_ty;
      shp_x_d      = rd_x;
      shp_y_d      = rd_y;
      shp_size_d   = rd_size;
      shp_rotate_d = rd_rotate;
      state_d      = S_PRESENT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      id_q         <= '0;
      shp_valid_q  <= 1'b0;
      shp_id_q     <= '0;
      shp_ty_q     <= '0;
      shp_x_q      <= '0;
      shp_y_q      <= '0;
      shp_size_q   <= '0;
      shp_rotate_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      id_q         <= id_d;
      shp_valid_q  <= shp_valid_d;
      shp_id_q     <= shp_id_d;
      shp_ty_q     <= shp_ty_d;
      shp_x_q      <= shp_x_d;
      shp_y_q      <= shp_y_d;
      shp_size_q   <= shp_size_d;
      shp_rotate_q <= shp_rotate_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rd_trigger = (state_q == S_TRIG);
  assign rd_id      = ((state_q == S_TRIG) || (state_q == S_WAIT) || (state_q == S_PRESENT))
                      ? id_q : '0;
  assign scan_busy  = (state_q != S_IDLE);
  assign scan_done  = (state_q == S_DONE);
  assign shp_valid  = shp_valid_q;
  assign shp_id     = shp_id_q;
  assign shp_ty     = shp_ty_q;
  assign shp_x      = shp_x_q;
  assign shp_y      = shp_y_q;
  assign shp_size   = shp_size_q;
  assign shp_rotate = shp_rotate_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_shape_scan_sched.sv
// Bench for shape_scan_sched: a reader/drawer model plus a transaction scoreboard.
// Honours SHAPE_SCAN_SKIP_EMPTY_EN the same way the design does.
module tb_shape_scan_sched;
  localparam int CORDW = 9;
  localparam int DATAW = 12;
  localparam int NUMW  = 12;

  typedef struct packed {
    logic [NUMW-1:0]  id;
    logic [DATAW-1:0] ty;
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic [DATAW-1:0] size;
    logic [DATAW-1:0] rot;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic [NUMW-1:0] shape_count = '0;
  logic [NUMW-1:0] rd_id;
  logic rd_trigger;
  logic rd_busy = 1'b0;
  logic [DATAW-1:0] rd_ty = '0;
  logic [CORDW-1:0] rd_x = '0;
  logic [CORDW-1:0] rd_y = '0;
  logic [DATAW-1:0] rd_size = '0;
  logic [DATAW-1:0] rd_rotate = '0;
  logic shp_valid;
  logic shp_ready = 1'b0;
  logic [NUMW-1:0] shp_id;
  logic [DATAW-1:0] shp_ty;
  logic [CORDW-1:0] shp_x;
  logic [CORDW-1:0] shp_y;
  logic [DATAW-1:0] shp_size;
  logic [DATAW-1:0] shp_rotate;
  logic scan_busy;
  logic scan_done;
  logic overrun;

  shape_scan_sched #(.CORDW(CORDW), .DATAW(DATAW), .NUMW(NUMW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .shape_count(shape_count),
    .rd_id(rd_id), .rd_trigger(rd_trigger), .rd_busy(rd_busy),
    .rd_ty(rd_ty), .rd_x(rd_x), .rd_y(rd_y), .rd_size(rd_size), .rd_rotate(rd_rotate),
    .shp_valid(shp_valid), .shp_ready(shp_ready), .shp_id(shp_id),
    .shp_ty(shp_ty), .shp_x(shp_x), .shp_y(shp_y), .shp_size(shp_size),
    .shp_rotate(shp_rotate), .scan_busy(scan_busy), .scan_done(scan_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // scoreboard / model state
  rec_t exp_q[$];
  int   cyc = 0;
  int   busy_len = 8;
  int   busy_left = 0;
  int   cur_count = 0;
  int   exp_trig_id = 0;
  int   fetch_id = 0;
  int   trig_cnt = 0;
  int   hs_cnt = 0;
  int   pres_cnt = 0;
  int   done_cnt = 0;
  int   trig_cyc = 0;
  int   last_hs_id = -1;
  bit   outstanding = 0;
  bit   prev_valid = 0;
  int   ready_mode = 0;   // 0 always ready, 1 random, 2 hold low for hold_left valid cycles
  int   hold_left = 0;
  bit   force_ty = 0;
  logic [DATAW-1:0] ty_tab [4];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reader, drawer and scoreboard all act on the falling edge, away from the DUT's edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rd_busy = 1'b0;
      busy_left = 0;
      outstanding = 0;
      prev_valid = 0;
      exp_q.delete();
    end else begin
      if (scan_done) done_cnt++;

      if (rd_trigger) begin
        check("trig_while_outstanding", {79'd0, outstanding}, 80'd0);
        check("rd_id_order", {68'd0, rd_id}, 80'(exp_trig_id));
        check("trig_in_range", {79'd0, exp_trig_id < cur_count}, 80'd1);
        fetch_id = exp_trig_id;
        exp_trig_id++;
        trig_cnt++;
        outstanding = 1;
        trig_cyc = cyc;
        rd_busy = 1'b1;
        busy_left = busy_len;
      end else if (rd_busy) begin
        busy_left--;
        if (busy_left == 0) begin
          rd_busy = 1'b0;
          rd_ty = force_ty ? ty_tab[fetch_id] : DATAW'($urandom);
          rd_x = CORDW'($urandom);
          rd_y = CORDW'($urandom);
          rd_size = DATAW'($urandom);
          rd_rotate = DATAW'($urandom);
`ifdef SHAPE_SCAN_SKIP_EMPTY_EN
          if (rd_ty == '0) outstanding = 0;
          else begin
            exp_q.push_back('{NUMW'(fetch_id), rd_ty, rd_x, rd_y, rd_size, rd_rotate});
            pres_cnt++;
          end
`else
          exp_q.push_back('{NUMW'(fetch_id), rd_ty, rd_x, rd_y, rd_size, rd_rotate});
          pres_cnt++;
`endif
        end
      end

      if (shp_valid) begin
        check("rec_available", {79'd0, exp_q.size() > 0}, 80'd1);
        if (exp_q.size() > 0)
          check("rec_fields", 80'({shp_id, shp_ty, shp_x, shp_y, shp_size, shp_rotate}),
                80'(exp_q[0]));
        if (!prev_valid)
          check("fetch_latency", 80'(cyc - trig_cyc), 80'(busy_len + 1));
      end
      prev_valid = shp_valid;

      case (ready_mode)
        0: shp_ready = 1'b1;
        1: shp_ready = 1'($urandom_range(0, 1));
        default: begin
          if (shp_valid && hold_left > 0) begin
            shp_ready = 1'b0;
            hold_left--;
          end else shp_ready = 1'b1;
        end
      endcase

      if (shp_valid && shp_ready && exp_q.size() > 0) begin
        last_hs_id = int'(shp_id);
        void'(exp_q.pop_front());
        hs_cnt++;
        outstanding = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [79:0] all_outs();
    return 80'({rd_id, rd_trigger, shp_valid, shp_id, shp_ty, shp_x, shp_y, shp_size,
                shp_rotate, scan_busy, scan_done, overrun});
  endfunction

  task automatic run_scan(input int n, input int b, input int inject, input bit done_pulse,
                          output int wait_k);
    busy_len = b;
    cur_count = n;
    exp_trig_id = 0;
    trig_cnt = 0;
    hs_cnt = 0;
    pres_cnt = 0;
    done_cnt = 0;
    shape_count = NUMW'(n);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_k = -1;
    for (int k = 0; k < 3000; k++) begin
      if (scan_done) begin
        wait_k = k;
        break;
      end
      frame_start = (k == inject);
      step();
    end
    frame_start = 1'b0;
    if (wait_k < 0) check("scan_done_timeout", 80'd0, 80'd1);
    check("trig_count", 80'(trig_cnt), 80'(n));
    check("hs_count", 80'(hs_cnt), 80'(pres_cnt));
    check("queue_drained", 80'(exp_q.size()), 80'd0);
    frame_start = done_pulse;
    step();
    frame_start = 1'b0;
    check("busy_after_done", {79'd0, scan_busy}, 80'd0);
    check("single_done", 80'(done_cnt), 80'd1);
  endtask

  int wk;

  initial begin
    for (int i = 0; i < 4; i++) ty_tab[i] = DATAW'(i + 1);
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("reset_idle_outputs", all_outs(), 80'd0);
    end

    // basic scan, always-ready drawer
    ready_mode = 0;
    run_scan(3, 8, -1, 1'b0, wk);
    check("basic_hs", 80'(hs_cnt), 80'd3);
    check("no_overrun", {79'd0, overrun}, 80'd0);

    // drawer stalls 10 cycles on the first record
    ready_mode = 2;
    hold_left = 10;
    run_scan(2, 3, -1, 1'b0, wk);
    check("stall_hs", 80'(hs_cnt), 80'd2);
    check("stall_consumed", 80'(hold_left), 80'd0);

    // empty table: DONE right after the sampling edge, no fetch
    ready_mode = 0;
    run_scan(0, 3, -1, 1'b0, wk);
    check("zero_done_delay", 80'(wk), 80'd0);
    check("zero_no_trig", 80'(trig_cnt), 80'd0);

    // frame_start mid-scan and again while DONE
    run_scan(3, 4, 5, 1'b1, wk);
    check("overrun_set", {79'd0, overrun}, 80'd1);
    repeat (4) step();
    check("no_restart_after_done", 80'(trig_cnt), 80'd3);
    check("overrun_sticky", {79'd0, overrun}, 80'd1);

    // randomized scans
    ready_mode = 1;
    for (int s = 0; s < 5; s++)
      run_scan($urandom_range(1, 5), $urandom_range(1, 6), -1, 1'b0, wk);
    check("overrun_still_sticky", {79'd0, overrun}, 80'd1);

    // empty-ty handling
    ready_mode = 0;
    force_ty = 1;
    ty_tab[0] = '0;
    ty_tab[1] = 12'd5;
    ty_tab[2] = '0;
    run_scan(3, 2, -1, 1'b0, wk);
`ifdef SHAPE_SCAN_SKIP_EMPTY_EN
    check("skip_hs", 80'(hs_cnt), 80'd1);
    check("skip_hs_id", 80'(last_hs_id), 80'd1);
`else
    check("noskip_hs", 80'(hs_cnt), 80'd3);
    check("noskip_last_id", 80'(last_hs_id), 80'd2);
`endif
    force_ty = 0;

    // reset while reader busy
    busy_len = 8;
    cur_count = 2;
    exp_trig_id = 0;
    shape_count = 12'd2;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (3) step();
    check("rst_test_in_wait", {79'd0, rd_busy}, 80'd1);
    rst = 1'b1;
    step();
    check("rst_mid_scan_outputs", all_outs(), 80'd0);
    rst = 1'b0;
    trig_cnt = 0;
    repeat (4) step();
    check("rst_no_stray_trig", 80'(trig_cnt), 80'd0);
    check("rst_idle_outputs", all_outs(), 80'd0);

    // scan runs normally after a mid-scan reset
    run_scan(2, 1, -1, 1'b0, wk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
